// File: rtl/collision_monitor_if.sv
// Signal bundle between the frame/position sources and collision_monitor.
// The master drives positions and frame_end; the slave returns the game status.
interface collision_monitor_if;
    logic       frame_end;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic [9:0] rival_x;
    logic [9:0] rival_y;
    logic       collide_with_rival;
    logic       scroll_en;
    logic [1:0] lives;
    logic       game_over;
    logic       hit_pulse;

    modport master (
        output frame_end, player_x, player_y, rival_x, rival_y,
        input  collide_with_rival, scroll_en, lives, game_over, hit_pulse
    );

    modport slave (
        input  frame_end, player_x, player_y, rival_x, rival_y,
        output collide_with_rival, scroll_en, lives, game_over, hit_pulse
    );
endinterface

// File: rtl/collision_monitor.sv
// Per-frame rival/wall collision detection with freeze timing and life accounting.
// Optional feature: define WALL_LIFE_LOSS_EN to make wall hits cost a life.
module collision_monitor #(
    parameter int unsigned OFFSET_BG_X   = 200,
    parameter int unsigned CAR_WIDTH     = 14,
    parameter int unsigned CAR_HEIGHT    = 16,
    parameter int unsigned BG_LEFT       = 44,
    parameter int unsigned BG_RIGHT      = 104,
    parameter int unsigned FREEZE_FRAMES = 30,
    parameter int unsigned LIVES         = 3
) (
    input logic                clk,
    input logic                reset_n,
    collision_monitor_if.slave bus
);
    localparam logic [1:0] RUN       = 2'd0;
    localparam logic [1:0] RIVAL_HIT = 2'd1;
    localparam logic [1:0] WALL_HIT  = 2'd2;
    localparam logic [1:0] OVER      = 2'd3;

`ifdef WALL_LIFE_LOSS_EN
    localparam bit WALL_COSTS_LIFE = 1'b1;
`else
    localparam bit WALL_COSTS_LIFE = 1'b0;
`endif

    localparam logic [10:0] WALL_LO    = 11'(OFFSET_BG_X + BG_LEFT);
    localparam logic [10:0] WALL_HI    = 11'(OFFSET_BG_X + BG_RIGHT);
    localparam logic [10:0] W          = 11'(CAR_WIDTH);
    localparam logic [10:0] H          = 11'(CAR_HEIGHT);
    localparam logic [7:0]  FREEZE_LD  = 8'(FREEZE_FRAMES);
    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);

    logic [1:0]  state, state_nx;
    logic [7:0]  freeze, freeze_nx, freeze_dec;
    logic [1:0]  lives_r, lives_nx, lives_dec;
    logic        pulse_nx;
    logic        collide_r, scroll_r, over_r, pulse_r;
    logic [10:0] px, py, rx, ry;
    logic        overlap, wall, cause;

    assign px = {1'b0, bus.player_x};
    assign py = {1'b0, bus.player_y};
    assign rx = {1'b0, bus.rival_x};
    assign ry = {1'b0, bus.rival_y};

    // Strict overlap: boxes that only share an edge do not collide.
    assign overlap = (px + W > rx) && (rx + W > px) && (py + H > ry) && (ry + H > py);
    assign wall    = (px < WALL_LO) || (px > WALL_HI);

    assign freeze_dec = (freeze == 8'd0) ? 8'd0 : freeze - 8'd1;
    assign lives_dec  = (lives_r == 2'd0) ? 2'd0 : lives_r - 2'd1;
    assign cause      = (state == RIVAL_HIT) ? overlap : wall;

    always_comb begin
        state_nx  = state;
        freeze_nx = freeze;
        lives_nx  = lives_r;
        pulse_nx  = 1'b0;
        if (bus.frame_end) begin
            case (state)
                RUN: begin
                    if (overlap) begin
                        state_nx  = RIVAL_HIT;
                        freeze_nx = FREEZE_LD;
                        lives_nx  = lives_dec;
                        pulse_nx  = 1'b1;
                    end else if (wall) begin
                        state_nx  = WALL_HIT;
                        freeze_nx = FREEZE_LD;
                        pulse_nx  = 1'b1;
                        if (WALL_COSTS_LIFE) lives_nx = lives_dec;
                    end
                end
                RIVAL_HIT, WALL_HIT: begin
                    freeze_nx = freeze_dec;
                    // Leave only once the freeze has run out and the cause has cleared.
                    if (freeze_dec == 8'd0 && !cause) begin
                        if (lives_r == 2'd0 && (state == RIVAL_HIT || WALL_COSTS_LIFE)) begin
                            state_nx = OVER;
                        end else begin
                            state_nx = RUN;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            freeze    <= 8'd0;
            lives_r   <= LIVES_INIT;
            collide_r <= 1'b0;
            scroll_r  <= 1'b1;
            over_r    <= 1'b0;
            pulse_r   <= 1'b0;
        end else begin
            state     <= state_nx;
            freeze    <= freeze_nx;
            lives_r   <= lives_nx;
            collide_r <= (state_nx == RIVAL_HIT) || (state_nx == OVER);
            scroll_r  <= (state_nx == RUN);
            over_r    <= (state_nx == OVER);
            pulse_r   <= pulse_nx;
        end
    end

    assign bus.collide_with_rival = collide_r;
    assign bus.scroll_en          = scroll_r;
    assign bus.lives              = lives_r;
    assign bus.game_over          = over_r;
    assign bus.hit_pulse          = pulse_r;
endmodule

// File: tb/tb_collision_monitor.sv
// Self-checking bench for collision_monitor: directed vector table, corner
// sequences and randomized frames against a behavioural game model.
module tb_collision_monitor;
    localparam int CW = 14, CH = 16, X0 = 200, BL = 44, BR = 104, FF = 30, LIVES = 3;
`ifdef WALL_LIFE_LOSS_EN
    localparam int WL = 1;
`else
    localparam int WL = 0;
`endif
    localparam int K_NONE = 0, K_RIVAL = 1, K_WALL = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    collision_monitor_if bus();
    collision_monitor dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int errors = 0;
    int checks = 0;

    typedef struct {
        string name;
        int    px, py, rx, ry, n;
        int    c, s, l, o, p;
    } vec_t;
    vec_t tbl[10];

    // Game model: which hit is active, frames left frozen, lives, game finished.
    int m_lives, m_freeze, m_kind;
    bit m_over, m_pulse;

    function automatic void model_reset();
        m_lives = LIVES; m_freeze = 0; m_kind = K_NONE; m_over = 0; m_pulse = 0;
    endfunction

    function automatic void model_frame(int px, int py, int rx, int ry);
        bit ov, wl, still;
        ov = (px + CW > rx) && (rx + CW > px) && (py + CH > ry) && (ry + CH > py);
        wl = (px < X0 + BL) || (px > X0 + BR);
        m_pulse = 0;
        if (m_over) return;
        if (m_kind == K_NONE) begin
            if (ov || wl) begin
                m_kind   = ov ? K_RIVAL : K_WALL;
                m_freeze = FF;
                m_pulse  = 1;
                if ((ov || WL == 1) && m_lives > 0) m_lives = m_lives - 1;
            end
        end else begin
            if (m_freeze > 0) m_freeze = m_freeze - 1;
            still = (m_kind == K_RIVAL) ? ov : wl;
            if (m_freeze == 0 && !still) begin
                if (m_lives == 0) m_over = 1;
                m_kind = K_NONE;
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input int s, input int l,
                           input int o, input int p);
        chk({tag, " collide"}, int'(bus.collide_with_rival), c);
        chk({tag, " scroll"}, int'(bus.scroll_en), s);
        chk({tag, " lives"}, int'(bus.lives), l);
        chk({tag, " game_over"}, int'(bus.game_over), o);
        chk({tag, " hit_pulse"}, int'(bus.hit_pulse), p);
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, int'(m_over || m_kind == K_RIVAL), int'(!m_over && m_kind == K_NONE),
                m_lives, int'(m_over), int'(m_pulse));
    endtask

    task automatic do_reset();
        bus.frame_end = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    // Outputs are sampled on the negedge right after the frame_end edge.
    task automatic frame(input int px, input int py, input int rx, input int ry);
        @(negedge clk);
        bus.player_x = 10'(px); bus.player_y = 10'(py);
        bus.rival_x  = 10'(rx); bus.rival_y  = 10'(ry);
        bus.frame_end = 1'b1;
        model_frame(px, py, rx, ry);
        @(negedge clk);
        bus.frame_end = 1'b0;
    endtask

    task automatic async_reset_check(input string tag);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk_all(tag, 0, 1, LIVES, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        bus.frame_end = 1'b0;
        bus.player_x = '0; bus.player_y = '0; bus.rival_x = '0; bus.rival_y = '0;

        tbl[0] = '{"touch_x", 250, 300, 264, 300, 1, 0, 1, 3, 0, 0};
        tbl[1] = '{"touch_y", 250, 300, 250, 316, 1, 0, 1, 3, 0, 0};
        tbl[2] = '{"hit_263", 250, 300, 263, 300, 1, 1, 0, 2, 0, 1};
        tbl[3] = '{"freeze29", 250, 300, 280, 150, 29, 1, 0, 2, 0, 0};
        tbl[4] = '{"freeze30", 250, 300, 280, 150, 1, 0, 1, 2, 0, 0};
        tbl[5] = '{"wall_240", 240, 300, 280, 150, 1, 0, 0, 2 - WL, 0, 1};
        tbl[6] = '{"wall_held", 240, 300, 280, 150, 30, 0, 0, 2 - WL, 0, 0};
        tbl[7] = '{"wall_exit", 250, 300, 280, 150, 1, 0, 1, 2 - WL, 0, 0};
        tbl[8] = '{"both_prio", 240, 300, 250, 300, 1, 1, 0, 1 - WL, 0, 1};
        tbl[9] = '{"both_exit", 250, 300, 280, 150, 30, WL, 1 - WL, 1 - WL, WL, 0};

        do_reset();
        chk_all("reset", 0, 1, 3, 0, 0);

        // Positions that would collide must be ignored while frame_end is low.
        @(negedge clk);
        bus.player_x = 10'd250; bus.player_y = 10'd300;
        bus.rival_x  = 10'd250; bus.rival_y  = 10'd300;
        repeat (5) @(negedge clk);
        chk_all("no_frame", 0, 1, 3, 0, 0);

        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < tbl[i].n; k++) frame(tbl[i].px, tbl[i].py, tbl[i].rx, tbl[i].ry);
            chk_all(tbl[i].name, tbl[i].c, tbl[i].s, tbl[i].l, tbl[i].o, tbl[i].p);
        end

        // Basic rival hit, pulse is one clock wide.
        do_reset();
        frame(250, 300, 250, 300);
        chk_all("basic_hit", 1, 0, 2, 0, 1);
        @(negedge clk);
        chk("basic_pulse_drop", int'(bus.hit_pulse), 0);

        // Three rival hits lead to game over, which then absorbs everything.
        do_reset();
        for (int h = 0; h < 3; h++) begin
            frame(250, 300, 250, 300);
            chk("over_seq hit lives", int'(bus.lives), 2 - h);
            repeat (FF) frame(250, 300, 280, 150);
        end
        chk_all("over_seq over", 1, 0, 0, 1, 0);
        frame(250, 300, 250, 300);
        frame(240, 300, 280, 150);
        frame(260, 300, 280, 150);
        chk_all("over_seq absorb", 1, 0, 0, 1, 0);
        async_reset_check("over_seq reset");

        // Reset in the middle of a freeze (counter at 12) acts without a clock.
        do_reset();
        frame(250, 300, 250, 300);
        repeat (FF - 12) frame(250, 300, 280, 150);
        chk_all("midfreeze", 1, 0, 2, 0, 0);
        async_reset_check("midfreeze reset");

        // Randomized frames against the model.
        do_reset();
        for (int it = 0; it < 800; it++) begin
            int px, py, rx, ry, r, gap;
            r = int'($urandom_range(0, 9));
            px = (r < 2) ? int'($urandom_range(200, 243)) :
                 (r < 3) ? int'($urandom_range(305, 330)) : int'($urandom_range(244, 304));
            py = int'($urandom_range(280, 320));
            if ($urandom_range(0, 1) == 0) begin
                rx = px + int'($urandom_range(0, 40)) - 20;
                ry = py + int'($urandom_range(0, 40)) - 20;
            end else begin
                rx = 280; ry = 150;
            end
            frame(px, py, rx, ry);
            chk_model("rand");
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("rand idle pulse", int'(bus.hit_pulse), 0);
            end
            if (m_over || $urandom_range(0, 99) == 0) async_reset_check("rand reset");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
